vco_adc_ti_decimator: RTL and testbench

//  Parametrised successor to the fixed 4-channel VCO-ADC front end.
//  - Takes NCH pairs of differential VCO phase-counter words (p/n), wrapping at BW bits.
//  - Per channel: forms first differences, subtracts p-n and removes a per-channel signed DC offset.
//  - Sums the NCH channels, then decimates by a runtime-programmable 2^DEC_LOG2 (1..2^DEC_MAX_LOG2).
//  - Replaces the fixed ripple-divider chains with a single-clock accumulate-and-dump.
//  - Sits between the ADC quantisers and the DFE/output mux.

---
 rtl/vco_adc_ti_decimator_pkg.sv | 32 +++
 rtl/vco_adc_ti_decimator_vco_diff_ch.sv | 55 +++++
 rtl/vco_adc_ti_decimator.sv | 129 ++++++++++++
 tb/tb_vco_adc_ti_decimator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vco_adc_ti_decimator_pkg.sv
// Shared width helpers for the VCO-ADC interleaved decimator.
// Keeps channel slicing and accumulator sizing consistent between top and channel.
package vco_adc_ti_decimator_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Per-sample channel sum: BW+2 bit channel words grown by log2(NCH)
  function automatic int sum_w(input int bw, input int nch);
    return bw + 2 + clog2(nch);
  endfunction

  // Accumulator holds up to 2^dmax channel sums without wrapping
  function automatic int acc_w(input int bw, input int nch, input int dmax);
    return sum_w(bw, nch) + dmax;
  endfunction

  function automatic int ch_lo(input int c, input int w);
    return c * w;
  endfunction

  function automatic int clamp_dec(input int v, input int dmax);
    return (v > dmax) ? dmax : v;
  endfunction

endpackage

// File: rtl/vco_adc_ti_decimator_vco_diff_ch.sv
// One VCO channel: wrap-safe first difference of p/n counters, p-n, minus DC offset.
// First sample after reset/enable only primes the previous-count registers.
module vco_diff_ch #(
  parameter int BW   = 6,
  parameter int OFFW = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   sample_en_i,
  input  logic [BW-1:0]          cnt_p_i,
  input  logic [BW-1:0]          cnt_n_i,
  input  logic signed [OFFW-1:0] dc_off_i,
  output logic signed [BW+1:0]   y_o,
  output logic                   y_vld_o
);

  logic [BW-1:0]        prev_p_q, prev_n_q;
  logic [BW-1:0]        dp, dn;
  logic signed [BW:0]   d;
  logic signed [BW+1:0] y_q, y_d;
  logic                 primed_q, y_vld_q;

  always_comb begin
    dp  = cnt_p_i - prev_p_q;
    dn  = cnt_n_i - prev_n_q;
    d   = $signed({1'b0, dp}) - $signed({1'b0, dn});
    y_d = {d[BW], d} - {{(BW + 2 - OFFW){dc_off_i[OFFW-1]}}, dc_off_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_p_q <= '0;
      prev_n_q <= '0;
      primed_q <= 1'b0;
      y_q      <= '0;
      y_vld_q  <= 1'b0;
    end else if (!enable_i) begin
      primed_q <= 1'b0;
      y_vld_q  <= 1'b0;
    end else if (sample_en_i) begin
      prev_p_q <= cnt_p_i;
      prev_n_q <= cnt_n_i;
      primed_q <= 1'b1;
      y_vld_q  <= primed_q;
      if (primed_q) y_q <= y_d;
    end else begin
      y_vld_q <= 1'b0;
    end
  end

  assign y_o     = y_q;
  assign y_vld_o = y_vld_q;

endmodule

// File: rtl/vco_adc_ti_decimator.sv
// Interleaved VCO-ADC front end: per-channel differencing, channel sum, and
// accumulate-and-dump decimation by 2^DEC_LOG2 with saturating, sticky-overflow output.
module vco_adc_ti_decimator
  import vco_adc_ti_decimator_pkg::*;
#(
  parameter int  NCH          = 4,
  parameter int  BW           = 6,
  parameter int  OFFW         = 3,
  parameter int  DEC_MAX_LOG2 = 7,
  parameter int  OUTW         = 21,
  localparam int DECW         = clog2(DEC_MAX_LOG2 + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   sample_en_i,
  input  logic [NCH*BW-1:0]      cnt_p_i,
  input  logic [NCH*BW-1:0]      cnt_n_i,
  input  logic [NCH*OFFW-1:0]    dc_off_i,
  input  logic [DECW-1:0]        dec_log2_i,
  output logic signed [OUTW-1:0] out_o,
  output logic                   out_valid_o,
  output logic                   ovf_o
);

  localparam int YW   = BW + 2;
  localparam int SW   = sum_w(BW, NCH);
  localparam int AW   = acc_w(BW, NCH, DEC_MAX_LOG2);
  localparam int EXTW = (AW > OUTW) ? AW : OUTW;
  localparam int CNTW = DEC_MAX_LOG2;
  localparam longint OMAXL = (longint'(1) << (OUTW - 1)) - 1;
  localparam longint OMINL = -(longint'(1) << (OUTW - 1));
  localparam logic signed [EXTW-1:0] OMAX = EXTW'(OMAXL);
  localparam logic signed [EXTW-1:0] OMIN = EXTW'(OMINL);

  logic signed [YW-1:0] y [NCH];
  logic [NCH-1:0]       y_vld;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    vco_diff_ch #(.BW(BW), .OFFW(OFFW)) u_ch (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .enable_i    (enable_i),
      .sample_en_i (sample_en_i),
      .cnt_p_i     (cnt_p_i[ch_lo(g, BW) +: BW]),
      .cnt_n_i     (cnt_n_i[ch_lo(g, BW) +: BW]),
      .dc_off_i    (dc_off_i[ch_lo(g, OFFW) +: OFFW]),
      .y_o         (y[g]),
      .y_vld_o     (y_vld[g])
    );
  end

  logic signed [AW-1:0]   acc_q, acc_d, tot;
  logic signed [EXTW-1:0] tot_x;
  logic signed [OUTW-1:0] out_q, out_d, sat_val;
  logic signed [SW-1:0]   s;
  logic [CNTW-1:0]        cnt_q, cnt_d, last_cnt;
  logic [DECW-1:0]        dec_q, dec_d, dec_now, dec_eff;
  logic                   out_vld_q, out_vld_d, ovf_q, ovf_d;
  logic                   s_vld, sat_hi, sat_lo;

  always_comb begin
    s = '0;
    for (int i = 0; i < NCH; i++) s = s + SW'(y[i]);
  end

  // Exponent is latched on the frame's first sum so mid-frame changes wait a frame
  always_comb begin
    s_vld    = &y_vld;
    dec_now  = DECW'(clamp_dec(int'(dec_log2_i), DEC_MAX_LOG2));
    dec_eff  = (cnt_q == '0) ? dec_now : dec_q;
    last_cnt = CNTW'((32'd1 << dec_eff) - 32'd1);
    tot      = acc_q + AW'(s);
    tot_x    = EXTW'(tot);
    sat_hi   = tot_x > OMAX;
    sat_lo   = tot_x < OMIN;
    if (sat_hi)      sat_val = OMAX[OUTW-1:0];
    else if (sat_lo) sat_val = OMIN[OUTW-1:0];
    else             sat_val = tot_x[OUTW-1:0];
  end

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dec_d     = dec_q;
    out_d     = out_q;
    out_vld_d = 1'b0;
    ovf_d     = ovf_q;
    if (!enable_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (s_vld) begin
      if (cnt_q == '0) dec_d = dec_now;
      if (cnt_q == last_cnt) begin
        out_d     = sat_val;
        out_vld_d = 1'b1;
        ovf_d     = ovf_q | sat_hi | sat_lo;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = tot;
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      dec_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dec_q     <= dec_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = out_vld_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_vco_adc_ti_decimator.sv
// Bench for vco_adc_ti_decimator: directed scenarios then random traffic,
// checked every cycle against a sample-level reference model (two OUTW variants).
module tb_vco_adc_ti_decimator;
  localparam int NCH = 4;
  localparam int BW = 6;
  localparam int OFFW = 3;
  localparam int MSK = (1 << BW) - 1;
  localparam int NCYC = 4096;

  logic clk_i = 1'b0;
  logic rst_ni, enable_i, sample_en_i;
  logic [NCH*BW-1:0] cnt_p_i, cnt_n_i;
  logic [NCH*OFFW-1:0] dc_off_i;
  logic [2:0] dec_log2_i;
  logic signed [20:0] out_w;
  logic signed [7:0] out_n;
  logic vld_w, ovf_w, vld_n, ovf_n;

  always #5 clk_i = ~clk_i;

  vco_adc_ti_decimator #(.OUTW(21)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .sample_en_i(sample_en_i),
    .cnt_p_i(cnt_p_i), .cnt_n_i(cnt_n_i), .dc_off_i(dc_off_i), .dec_log2_i(dec_log2_i),
    .out_o(out_w), .out_valid_o(vld_w), .ovf_o(ovf_w));

  vco_adc_ti_decimator #(.OUTW(8)) dut_s (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .sample_en_i(sample_en_i),
    .cnt_p_i(cnt_p_i), .cnt_n_i(cnt_n_i), .dc_off_i(dc_off_i), .dec_log2_i(dec_log2_i),
    .out_o(out_n), .out_valid_o(vld_n), .ovf_o(ovf_n));

  int n_pass = 0, n_fail = 0, n_total = 0;
  int cyc = 0;
  bit exp_vld[NCYC];
  int exp_val[NCYC];
  int cp[NCH], cn[NCH], off[NCH];
  int dec;
  int m_pp[NCH], m_pn[NCH];
  bit m_primed;
  int m_acc, m_cnt, m_dec;
  int hold_w, hold_n;
  bit movf_w, movf_n;

  function automatic int sat(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
    n_total++;
    assert (obs === req) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0d required=%0d", tag, cyc, obs, req);
    end
  endtask

  task automatic adv(input int dp, input int dn);
    for (int c = 0; c < NCH; c++) begin
      cp[c] = (cp[c] + dp) & MSK;
      cn[c] = (cn[c] + dn) & MSK;
    end
  endtask

  task automatic cyc_step(input bit en, input bit se);
    int s, dp, dn;
    @(negedge clk_i);
    if (exp_vld[cyc]) begin
      hold_w = sat(exp_val[cyc], 21);
      hold_n = sat(exp_val[cyc], 8);
      if (hold_w != exp_val[cyc]) movf_w = 1'b1;
      if (hold_n != exp_val[cyc]) movf_n = 1'b1;
    end
    chk("vld_w", vld_w, exp_vld[cyc]);
    chk("out_w", out_w, hold_w);
    chk("ovf_w", ovf_w, movf_w);
    chk("vld_n", vld_n, exp_vld[cyc]);
    chk("out_n", out_n, hold_n);
    chk("ovf_n", ovf_n, movf_n);
    enable_i = en;
    sample_en_i = se;
    dec_log2_i = 3'(dec);
    for (int c = 0; c < NCH; c++) begin
      cnt_p_i[c*BW +: BW] = 6'(cp[c]);
      cnt_n_i[c*BW +: BW] = 6'(cn[c]);
      dc_off_i[c*OFFW +: OFFW] = 3'(off[c]);
    end
    if (!en) begin
      m_primed = 1'b0;
      m_acc = 0;
      m_cnt = 0;
      exp_vld[cyc+1] = 1'b0;
    end else if (se) begin
      if (m_primed) begin
        s = 0;
        for (int c = 0; c < NCH; c++) begin
          dp = (cp[c] - m_pp[c]) & MSK;
          dn = (cn[c] - m_pn[c]) & MSK;
          s += dp - dn - off[c];
        end
        if (m_cnt == 0) m_dec = dec;
        m_acc += s;
        m_cnt++;
        if (m_cnt == (1 << m_dec)) begin
          exp_vld[cyc+2] = 1'b1;
          exp_val[cyc+2] = m_acc;
          m_acc = 0;
          m_cnt = 0;
        end
      end
      m_primed = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        m_pp[c] = cp[c];
        m_pn[c] = cn[c];
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input string tag);
    rst_ni = 1'b0;
    #1;
    chk({tag, "_out_w"}, out_w, 0);
    chk({tag, "_vld_w"}, vld_w, 0);
    chk({tag, "_ovf_w"}, ovf_w, 0);
    chk({tag, "_out_n"}, out_n, 0);
    chk({tag, "_ovf_n"}, ovf_n, 0);
    m_primed = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    m_dec = 0;
    hold_w = 0;
    hold_n = 0;
    movf_w = 1'b0;
    movf_n = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_pp[c] = 0;
      m_pn[c] = 0;
    end
    for (int i = cyc; i < NCYC; i++) exp_vld[i] = 1'b0;
    cyc_step(1'b0, 1'b0);
    cyc_step(1'b0, 1'b0);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b1;
    enable_i = 1'b0;
    sample_en_i = 1'b0;
    cnt_p_i = '0;
    cnt_n_i = '0;
    dc_off_i = '0;
    dec_log2_i = '0;
    dec = 2;
    for (int c = 0; c < NCH; c++) begin
      cp[c] = 0;
      cn[c] = 0;
      off[c] = 0;
    end
    #2;
    do_reset("por");

    // Baseline: d=2 per channel, sum 8, four samples per frame
    for (int c = 0; c < NCH; c++) begin
      cp[c] = 10 * c;
      cn[c] = 3 * c;
    end
    for (int k = 0; k < 17; k++) begin cyc_step(1, 1); adv(5, 3); end
    cyc_step(1, 0); cyc_step(1, 0);
    chk("t1_out", out_w, 32);

    // Counter wrap 62 -> 3 -> 8 on the p side
    cyc_step(0, 0);
    for (int c = 0; c < NCH; c++) begin
      cp[c] = 62;
      cn[c] = 7 + c;
    end
    for (int k = 0; k < 5; k++) begin cyc_step(1, 1); adv(5, 0); end
    cyc_step(1, 0); cyc_step(1, 0);
    chk("t2_wrap_out", out_w, 80);

    // DC offsets +1 on ch0, -2 on ch3
    cyc_step(0, 0);
    off[0] = 1;
    off[3] = -2;
    for (int k = 0; k < 9; k++) begin cyc_step(1, 1); adv(5, 3); end
    cyc_step(1, 0); cyc_step(1, 0);
    chk("t3_off_out", out_w, 36);
    chk("t3_off_out_n", out_n, 36);
    off[0] = 0;
    off[3] = 0;

    // Decimation exponent 2 -> 0 in the middle of a frame
    cyc_step(0, 0);
    for (int k = 0; k < 3; k++) begin cyc_step(1, 1); adv(5, 3); end
    dec = 0;
    for (int k = 0; k < 6; k++) begin cyc_step(1, 1); adv(5, 3); end
    cyc_step(1, 0); cyc_step(1, 0);
    chk("t4_dec0_out", out_w, 8);

    // Enable dropped mid-frame, samples while disabled are ignored
    dec = 2;
    cyc_step(0, 0);
    for (int k = 0; k < 7; k++) begin cyc_step(1, 1); adv(5, 3); end
    cyc_step(0, 1); cyc_step(0, 1);
    for (int k = 0; k < 5; k++) begin cyc_step(1, 1); adv(5, 3); end
    cyc_step(1, 0); cyc_step(1, 0);
    chk("t5_reen_out", out_w, 32);
    for (int k = 0; k < 3; k++) begin cyc_step(1, 1); adv(5, 3); end
    do_reset("t5_res");

    // Saturation of the narrow variant with maximum positive differences
    dec = 7;
    for (int c = 0; c < NCH; c++) begin
      cp[c] = 0;
      cn[c] = 5;
    end
    for (int k = 0; k < 129; k++) begin cyc_step(1, 1); adv(63, 0); end
    cyc_step(1, 0); cyc_step(1, 0);
    chk("t6_out_n", out_n, 127);
    chk("t6_ovf_n", ovf_n, 1);
    chk("t6_out_w", out_w, 32256);
    chk("t6_ovf_w", ovf_w, 0);
    cyc_step(0, 0); cyc_step(0, 0); cyc_step(0, 0);
    chk("t6_ovf_sticky", ovf_n, 1);
    do_reset("t6_res");

    // Random traffic, exponent and offsets changed only while disabled
    for (int seg = 0; seg < 12; seg++) begin
      dec = $urandom_range(0, 5);
      for (int c = 0; c < NCH; c++) off[c] = $urandom_range(0, 7) - 4;
      cyc_step(0, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 40; k++) begin
        for (int c = 0; c < NCH; c++) begin
          cp[c] = $urandom_range(0, MSK);
          cn[c] = $urandom_range(0, MSK);
        end
        cyc_step($urandom_range(0, 29) != 0, $urandom_range(0, 3) != 0);
      end
    end
    cyc_step(1, 0); cyc_step(1, 0); cyc_step(1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
